// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline-stage buffer family.
//   occ_t                      : occupancy encoding (entries held by a stage buffer)
//   OCC_EMPTY/OCC_ONE/OCC_FULL : legal occupancy values
//   NOP_WORD                   : payload value that decodes as a bubble downstream
package pipe_pkg;
   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_FULL  = 2'd2;

   localparam int NOP_WORD = 0;
endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// sat_counter -- saturating up-counter for performance profiling.
//   clk   in  clock
//   rst   in  synchronous active-high clear
//   inc   in  count this cycle
//   count out current value; sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);
   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst)
         count_reg <= '0;
      else if (inc && (count_reg != {W{1'b1}}))
         count_reg <= count_reg + 1'b1;
   end

   assign count = count_reg;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- generic pipeline-stage register with valid/ready handshake
// and a 2-entry skid buffer (main register + skid register).
//   clk, rst            clock / synchronous active-high reset
//   flush               squash every buffered entry; same-cycle input is dropped
//   in_valid/in_ready   upstream handshake; in_ready is a flop
//   in_data             upstream payload
//   out_valid/out_ready downstream handshake
//   out_data            downstream payload (always the main register)
//   occupancy           entries held, 0..2
//   stall_cnt           saturating count of cycles with out_valid && !out_ready
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter bit CLEAR_ON_FLUSH = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);
   localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_WORD);

   occ_t              occ_reg, occ_next;
   logic [DATA_W-1:0] main_reg, main_next;
   logic [DATA_W-1:0] skid_reg, skid_next;
   logic              in_ready_reg, in_ready_next;
   logic              in_xfer, out_xfer;

   assign out_valid = (occ_reg != OCC_EMPTY);
   assign in_xfer   = in_valid && in_ready_reg;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      occ_next  = occ_reg;
      main_next = main_reg;
      skid_next = skid_reg;
      if (flush) begin
         occ_next = OCC_EMPTY;
         if (CLEAR_ON_FLUSH) begin
            main_next = NOP;
            skid_next = NOP;
         end
      end else begin
         case (occ_reg)
            OCC_EMPTY: begin
               if (in_xfer) begin
                  main_next = in_data;
                  occ_next  = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_next = in_data;
               end else if (in_xfer) begin
                  // Downstream stalled: park the new word behind the main one.
                  skid_next = in_data;
                  occ_next  = OCC_FULL;
               end else if (out_xfer) begin
                  occ_next = OCC_EMPTY;
                  if (CLEAR_ON_FLUSH)
                     main_next = NOP;
               end
            end
            OCC_FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_xfer) begin
                  main_next = skid_reg;
                  occ_next  = OCC_ONE;
               end
            end
            default: begin
               occ_next = OCC_EMPTY;
            end
         endcase
      end
      // Ready is decided from the state we are about to enter, which keeps
      // it a flop with no combinational path from out_ready.
      in_ready_next = (occ_next < OCC_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_reg      <= OCC_EMPTY;
         main_reg     <= NOP;
         skid_reg     <= NOP;
         in_ready_reg <= 1'b1;
      end else begin
         occ_reg      <= occ_next;
         main_reg     <= main_next;
         skid_reg     <= skid_next;
         in_ready_reg <= in_ready_next;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid && !out_ready),
      .count (stall_cnt)
   );

   assign in_ready  = in_ready_reg;
   assign out_data  = main_reg;
   assign occupancy = occ_reg;

   a_occ_range: assert property (@(posedge clk) disable iff (rst) occ_reg <= OCC_FULL);
   a_ready_occ: assert property (@(posedge clk) disable iff (rst)
                                 in_ready_reg == (occ_reg < OCC_FULL));
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf -- directed bench with a scoreboard queue.
// The stimulus pushes each word it expects to leave the buffer; an independent
// monitor pops and compares on every output transfer of the main instance.
// A second instance with CLEAR_ON_FLUSH=0 shares the stimulus.
module tb_pipe_stage_buf;
   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [DW-1:0] in_data;

   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt;

   logic          nc_in_ready, nc_out_valid;
   logic [DW-1:0] nc_out_data;
   logic [1:0]    nc_occupancy;
   logic [CW-1:0] nc_stall_cnt;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_stage_buf #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b0), .CNT_W(CW)) dut_nc (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data),
      .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data),
      .occupancy(nc_occupancy), .stall_cnt(nc_stall_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one edge and settle 1 time unit past it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples on the falling edge, i.e. mid-cycle before the transfer edge.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got 0x%0h, expected no transfer", out_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL out_data_order: got 0x%0h, expected 0x%0h", out_data, e);
            end else begin
               $display("xfer out data=0x%0h", out_data);
            end
         end
      end
   end

   initial begin
      // 1 Reset with in_valid high
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
      cyc(); cyc();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_occ",       32'(occupancy), 32'd0);
      chk("rst_out_data",  out_data,       32'd0);
      chk("rst_stall",     32'(stall_cnt), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      cyc();

      // 2 Streaming
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         logic [DW-1:0] v;
         v = 32'h11 * (i + 1);
         in_valid = 1'b1; in_data = v; exp_q.push_back(v);
         cyc();
         chk("stream_occ",  32'(occupancy), 32'd1);
         chk("stream_data", out_data,       v);
      end
      in_valid = 1'b0;
      cyc();
      chk("stream_drain_occ",  32'(occupancy), 32'd0);
      chk("stream_drain_data", out_data,       32'd0);
      chk("stream_stall",      32'(stall_cnt), 32'd0);

      // 3 Backpressure
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA; exp_q.push_back(32'hA);
      cyc();
      chk("bp_occ1",   32'(occupancy), 32'd1);
      chk("bp_ready1", 32'(in_ready),  32'd1);
      in_data = 32'hB; exp_q.push_back(32'hB);
      cyc();
      chk("bp_occ2",   32'(occupancy), 32'd2);
      chk("bp_ready2", 32'(in_ready),  32'd0);
      chk("bp_head",   out_data,       32'hA);
      in_data = 32'hC;
      cyc();
      chk("bp_c_refused_occ", 32'(occupancy), 32'd2);
      chk("bp_c_refused_head", out_data,      32'hA);
      chk("bp_stall",  32'(stall_cnt), 32'd2);
      out_ready = 1'b1; exp_q.push_back(32'hC);
      cyc();
      chk("bp_rel_occ",   32'(occupancy), 32'd1);
      chk("bp_rel_data",  out_data,       32'hB);
      chk("bp_rel_ready", 32'(in_ready),  32'd1);
      cyc();
      chk("bp_c_data", out_data, 32'hC);
      in_valid = 1'b0;
      cyc();
      chk("bp_empty_occ", 32'(occupancy), 32'd0);
      chk("bp_q_drained", 32'(exp_q.size()), 32'd0);

      // 4 Flush with occupancy 2; 0xD presented in the flush cycle must be dropped
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA; cyc();
      in_data = 32'hB; cyc();
      chk("fl_pre_occ", 32'(occupancy), 32'd2);
      flush = 1'b1; in_data = 32'hD;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_occ",       32'(occupancy),    32'd0);
      chk("fl_out_valid", 32'(out_valid),    32'd0);
      chk("fl_out_data",  out_data,          32'd0);
      chk("fl_in_ready",  32'(in_ready),     32'd1);
      chk("fl_nc_hold",   nc_out_data,       32'hA);
      chk("fl_stall",     32'(stall_cnt),    32'd4);
      out_ready = 1'b1;
      cyc(); cyc();
      chk("fl_no_d_occ", 32'(occupancy), 32'd0);

      // 5 Stall counter saturation (CNT_W=4)
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) cyc();
      chk("sat_stall", 32'(stall_cnt), 32'd15);
      flush = 1'b1; cyc(); flush = 1'b0;
      chk("sat_after_flush", 32'(stall_cnt), 32'd15);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("sat_after_rst", 32'(stall_cnt), 32'd0);

      // 6 Reset beats flush; then CLEAR_ON_FLUSH=0 flush keeps the payload
      in_valid = 1'b1; in_data = 32'h66;
      cyc();
      chk("rp_pre_occ", 32'(occupancy), 32'd1);
      in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
      cyc();
      rst = 1'b0; flush = 1'b0;
      chk("rp_occ",       32'(occupancy),    32'd0);
      chk("rp_out_valid", 32'(out_valid),    32'd0);
      chk("rp_out_data",  out_data,          32'd0);
      chk("rp_in_ready",  32'(in_ready),     32'd1);
      chk("rp_nc_data",   nc_out_data,       32'd0);
      in_valid = 1'b1; in_data = 32'h99;
      cyc();
      chk("nc_load", nc_out_data, 32'h99);
      in_valid = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("nc_flush_valid", 32'(nc_out_valid), 32'd0);
      chk("nc_flush_data",  nc_out_data,       32'h99);
      chk("nc_flush_ready", 32'(nc_in_ready),  32'd1);
      chk("main_flush_data", out_data,         32'd0);
      cyc();
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
